// File: rtl/two_layer_matmul_if.sv
`default_nettype none
// ============================================================================
//  Module   : two_layer_matmul_if
//  Purpose  : Beat/result bundle between the operand feeder and the
//             two_layer_matmul engine.
//  Signals  : valid_i  - end-of-stream marker, qualified by en_i
//             en_i     - beat enable
//             din1_i   - stage-1 matrix column, N lanes of DW bits
//             din2_i   - stage-1 weight element
//             din3_i   - stage-2 vector element
//             done_o   - one-cycle pulse when matmul_o is updated
//             matmul_o - N results of OW bits
//  Modports : master (feeder / sink side), slave (engine side)
//  Revision : 1.0 - initial release
// ============================================================================
interface two_layer_matmul_if #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int OW = 32
);
  logic              valid_i;
  logic              en_i;
  logic [N*DW-1:0]   din1_i;
  logic [DW-1:0]     din2_i;
  logic [DW-1:0]     din3_i;
  logic              done_o;
  logic [N*OW-1:0]   matmul_o;

  modport master (
    output valid_i, en_i, din1_i, din2_i, din3_i,
    input  done_o, matmul_o
  );

  modport slave (
    input  valid_i, en_i, din1_i, din2_i, din3_i,
    output done_o, matmul_o
  );
endinterface
`default_nettype wire

// File: rtl/two_layer_matmul.sv
`default_nettype none
// ============================================================================
//  Module   : two_layer_matmul
//  Purpose  : Streaming two-stage matrix-vector engine. Stage 1 builds an
//             NxN hidden matrix H one column at a time (column c = X_c * w_c,
//             X_c streamed as N-lane columns, w_c as scalars). Stage 2
//             streams an N-vector v and emits y = H * v with a done pulse.
//  Ports    : clk_i  - clock, rising edge
//             rstn_i - asynchronous reset, active-high (1 = reset)
//             bus    - two_layer_matmul_if.slave (beat inputs, results)
//  Revision : 1.0 - initial release
// ============================================================================
module two_layer_matmul #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int HW = 20,
  parameter int OW = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  two_layer_matmul_if.slave   bus
);

  localparam int              CW       = $clog2(N);
  localparam int              PW1      = 2 * DW;     // stage-1 product width
  localparam int              PW2      = HW + DW;    // stage-2 product width
  localparam logic [CW-1:0]   COL_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_STAGE1 = 1'b0,
    ST_STAGE2 = 1'b1
  } phase_t;

  phase_t          r_phase;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   r_k;
  logic            r_done;
  logic [HW-1:0]   r_acc1 [N];
  logic [HW-1:0]   r_h    [N][N];
  logic [OW-1:0]   r_acc2 [N];
  logic [OW-1:0]   r_y    [N];

  logic [PW1-1:0]  w_prod1 [N];
  logic [PW2-1:0]  w_prod2 [N];
  logic [HW-1:0]   w_sum1  [N];
  logic [OW-1:0]   w_sum2  [N];

  // Per-lane MACs. The sums include the current beat's product so that a
  // commit beat can store the complete column / result in the same cycle.
  generate
    for (genvar r = 0; r < N; r++) begin : g_lane
      assign w_prod1[r] = {{DW{1'b0}}, bus.din1_i[r*DW +: DW]}
                        * {{DW{1'b0}}, bus.din2_i};
      assign w_prod2[r] = {{DW{1'b0}}, r_h[r][r_k]}
                        * {{HW{1'b0}}, bus.din3_i};
      assign w_sum1[r]  = r_acc1[r] + {{(HW-PW1){1'b0}}, w_prod1[r]};
      assign w_sum2[r]  = r_acc2[r] + {{(OW-PW2){1'b0}}, w_prod2[r]};
      assign bus.matmul_o[r*OW +: OW] = r_y[r];
    end
  endgenerate

  assign bus.done_o = r_done;

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      r_phase <= ST_STAGE1;
      r_col   <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        r_acc1[r] <= '0;
        r_acc2[r] <= '0;
        r_y[r]    <= '0;
        for (int c = 0; c < N; c++) begin
          r_h[r][c] <= '0;
        end
      end
    end else begin
      r_done <= 1'b0;
      if (bus.en_i) begin
        case (r_phase)
          ST_STAGE1: begin
            if (bus.valid_i) begin
              for (int r = 0; r < N; r++) begin
                r_h[r][r_col] <= w_sum1[r];
                r_acc1[r]     <= '0;
              end
              if (r_col == COL_LAST) begin
                r_col   <= '0;
                r_phase <= ST_STAGE2;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end else begin
              for (int r = 0; r < N; r++) begin
                r_acc1[r] <= w_sum1[r];
              end
            end
          end

          ST_STAGE2: begin
            if (bus.valid_i) begin
              // Result commit: publish y, then return to a clean stage 1
              // with H wiped so the next run starts from zero.
              for (int r = 0; r < N; r++) begin
                r_y[r]    <= w_sum2[r];
                r_acc2[r] <= '0;
                for (int c = 0; c < N; c++) begin
                  r_h[r][c] <= '0;
                end
              end
              r_k     <= '0;
              r_done  <= 1'b1;
              r_phase <= ST_STAGE1;
            end else begin
              for (int r = 0; r < N; r++) begin
                r_acc2[r] <= w_sum2[r];
              end
              // Wraps naturally past N-1, re-using H columns.
              r_k <= r_k + 1'b1;
            end
          end

          default: r_phase <= ST_STAGE1;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_two_layer_matmul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_two_layer_matmul
//  Purpose  : Scoreboard bench for two_layer_matmul. The driver pushes the
//             reference result when it issues a stage-2 commit beat; a
//             monitor pops and compares whenever done_o is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_two_layer_matmul;

  localparam int N  = 8;
  localparam int OW = 32;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b1;

  two_layer_matmul_if #(.N(8), .DW(8), .OW(32)) bus ();

  two_layer_matmul #(.N(8), .DW(8), .HW(20), .OW(32)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N*OW-1:0] exp_q [$];

  // Reference model: H as plain integers, arithmetic taken modulo 2^20 for
  // hidden values and modulo 2^32 (natural int unsigned wrap) for outputs.
  int unsigned m_acc1 [N];
  int unsigned m_h    [N][N];
  int unsigned m_acc2 [N];
  int          m_col;
  int          m_k;
  bit          m_st2;

  function automatic void model_clear();
    for (int r = 0; r < N; r++) begin
      m_acc1[r] = 0;
      m_acc2[r] = 0;
      for (int c = 0; c < N; c++) m_h[r][c] = 0;
    end
    m_col = 0;
    m_k   = 0;
    m_st2 = 0;
  endfunction

  function automatic logic [63:0] bytes_all(input logic [7:0] b);
    return {8{b}};
  endfunction

  // One enabled beat: drive at negedge, advance the model.
  task automatic beat(input bit v, input logic [63:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    logic [N*OW-1:0] y;
    @(negedge clk_i);
    bus.en_i    = 1'b1;
    bus.valid_i = v;
    bus.din1_i  = d1;
    bus.din2_i  = d2;
    bus.din3_i  = d3;
    if (!m_st2) begin
      for (int r = 0; r < N; r++) begin
        m_acc1[r] = (m_acc1[r] + int'(d1[8*r +: 8]) * int'(d2)) % 32'h0010_0000;
      end
      if (v) begin
        for (int r = 0; r < N; r++) begin
          m_h[r][m_col] = m_acc1[r];
          m_acc1[r] = 0;
        end
        m_col++;
        if (m_col == N) begin
          m_col = 0;
          m_st2 = 1;
        end
      end
    end else begin
      for (int r = 0; r < N; r++) m_acc2[r] = m_acc2[r] + m_h[r][m_k] * int'(d3);
      m_k = (m_k + 1) % N;
      if (v) begin
        for (int r = 0; r < N; r++) y[32*r +: 32] = m_acc2[r];
        exp_q.push_back(y);
        model_clear();
      end
    end
  endtask

  // Disabled cycle with valid_i high and junk data: must change nothing.
  task automatic stall();
    @(negedge clk_i);
    bus.en_i    = 1'b0;
    bus.valid_i = 1'b1;
    bus.din1_i  = {$urandom, $urandom};
    bus.din2_i  = 8'($urandom);
    bus.din3_i  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      bus.en_i    = 1'b0;
      bus.valid_i = 1'b0;
    end
  endtask

  task automatic ones_stage1(input bit with_stalls);
    for (int c = 0; c < N; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (with_stalls && (b == 2)) stall();
        beat(b == 3, bytes_all(8'd1), 8'd1, 8'($urandom));
      end
    end
  endtask

  task automatic const_stage2(input logic [7:0] v);
    for (int k = 0; k < N; k++) beat(k == N - 1, {$urandom, $urandom}, 8'($urandom), v);
  endtask

  // Directed check of every lane against a hand-derived constant, taken on
  // the negedge right after the commit beat.
  task automatic check_y(input string name, input int unsigned want);
    @(negedge clk_i);
    bus.en_i    = 1'b0;
    bus.valid_i = 1'b0;
    for (int r = 0; r < N; r++) begin
      n_tests++;
      if (bus.matmul_o[32*r +: 32] !== want) begin
        n_fail++;
        $display("FAIL %s y[%0d]: got %0d expected %0d", name, r,
                 bus.matmul_o[32*r +: 32], want);
      end
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_i);
    bus.en_i    = 1'b0;
    bus.valid_i = 1'b0;
    #2 rstn_i = 1'b1;
    model_clear();
    #1;
    n_tests++;
    if (bus.done_o !== 1'b0 || bus.matmul_o !== '0) begin
      n_fail++;
      $display("FAIL %s: got done=%b y=%h expected done=0 y=0", name,
               bus.done_o, bus.matmul_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b0;
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rstn_i && bus.done_o === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: got done=1 y=%h expected done=0", bus.matmul_o);
      end else begin
        logic [N*OW-1:0] e;
        e = exp_q.pop_front();
        if (bus.matmul_o !== e) begin
          n_fail++;
          $display("FAIL scoreboard_y: got %h expected %h", bus.matmul_o, e);
        end
      end
    end
  end

  initial begin
    logic [63:0] col0 [4];
    logic [7:0]  w0   [4];

    bus.en_i    = 1'b0;
    bus.valid_i = 1'b0;
    bus.din1_i  = '0;
    bus.din2_i  = '0;
    bus.din3_i  = '0;
    model_clear();

    // Reset state
    repeat (2) @(negedge clk_i);
    n_tests++;
    if (bus.done_o !== 1'b0 || bus.matmul_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got done=%b y=%h expected done=0 y=0",
               bus.done_o, bus.matmul_o);
    end
    rstn_i = 1'b0;
    idle(2);

    // All-ones
    ones_stage1(1'b0);
    const_stage2(8'd1);
    check_y("all_ones", 32);
    idle(3);

    // Column select (row 0 is the low byte)
    col0[0] = {8'd1, 8'd2, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1}; w0[0] = 8'd1;
    col0[1] = {8'd2, 8'd3, 8'd1, 8'd2, 8'd2, 8'd1, 8'd3, 8'd1}; w0[1] = 8'd1;
    col0[2] = {8'd3, 8'd2, 8'd1, 8'd3, 8'd1, 8'd1, 8'd2, 8'd1}; w0[2] = 8'd2;
    col0[3] = {8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2}; w0[3] = 8'd1;
    for (int b = 0; b < 4; b++) beat(b == 3, col0[b], w0[b], 8'($urandom));
    for (int c = 1; c < N; c++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++)
        beat(b == nb - 1, {$urandom, $urandom}, 8'($urandom), 8'($urandom));
    end
    for (int k = 0; k < N; k++) beat(k == N - 1, 64'h0, 8'h0, (k == 0) ? 8'd1 : 8'd0);
    @(negedge clk_i);
    bus.en_i = 1'b0;
    bus.valid_i = 1'b0;
    begin
      int unsigned want [N] = '{6, 11, 6, 7, 10, 6, 10, 10};
      for (int r = 0; r < N; r++) begin
        n_tests++;
        if (bus.matmul_o[32*r +: 32] !== want[r]) begin
          n_fail++;
          $display("FAIL column_select y[%0d]: got %0d expected %0d", r,
                   bus.matmul_o[32*r +: 32], want[r]);
        end
      end
    end
    idle(2);

    // Stalls mid-stream, then a zero-data commit for column 7
    for (int c = 0; c < N; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 1) stall();
        beat((b == 3) && (c != N - 1), bytes_all(8'd1), 8'd1, 8'($urandom));
      end
    end
    beat(1'b1, 64'h0, 8'h0, 8'h0);
    for (int k = 0; k < N; k++) begin
      if (k == 4) stall();
      beat(k == N - 1, {$urandom, $urandom}, 8'($urandom), 8'd1);
    end
    check_y("stall_zero_commit", 32);
    idle(2);

    // Overflow-range operands
    for (int c = 0; c < N; c++)
      for (int b = 0; b < 4; b++) beat(b == 3, bytes_all(8'hFF), 8'hFF, 8'hFF);
    const_stage2(8'hFF);
    check_y("overflow", 530604000);
    idle(2);

    // Hidden accumulator wrap: 20 * 65025 mod 2^20 = 251924
    for (int b = 0; b < 20; b++) beat(b == 19, bytes_all(8'hFF), 8'hFF, 8'h0);
    for (int c = 1; c < N; c++) beat(1'b1, bytes_all(8'hFF), 8'hFF, 8'h0);
    beat(1'b1, 64'h0, 8'h0, 8'd1);
    check_y("hidden_wrap", 251924);
    idle(2);

    // Reset mid-stage-2, then rerun
    ones_stage1(1'b0);
    for (int k = 0; k < 3; k++) beat(1'b0, 64'h0, 8'h0, 8'd1);
    do_reset("reset_mid_stage2");
    idle(3);
    ones_stage1(1'b0);
    const_stage2(8'd1);
    check_y("after_reset", 32);

    // Back-to-back runs
    ones_stage1(1'b1);
    const_stage2(8'd1);
    check_y("b2b_first", 32);
    ones_stage1(1'b0);
    const_stage2(8'd2);
    check_y("b2b_second", 64);
    idle(2);

    // Randomized runs: variable beats per column, stalls, k wrap
    for (int run = 0; run < 6; run++) begin
      int nk;
      for (int c = 0; c < N; c++) begin
        int nb;
        nb = $urandom_range(1, 20);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) stall();
          beat(b == nb - 1, {$urandom, $urandom}, 8'($urandom), 8'($urandom));
        end
      end
      nk = $urandom_range(1, 12);
      for (int k = 0; k < nk; k++) begin
        if ($urandom_range(0, 3) == 0) stall();
        beat(k == nk - 1, {$urandom, $urandom}, 8'($urandom), 8'($urandom));
      end
      idle($urandom_range(0, 2));
    end

    idle(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL outstanding_results: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/two_layer_matmul.md
Name: two_layer_matmul

Overview:
- Streaming two-stage matrix-vector engine built from 8 unsigned 8-bit lanes.
- Stage 1 computes eight hidden columns: each column is X_j·w_j, where X_j is a streamed 8×K matrix and w_j a streamed K-vector. The eight columns form an 8×8 hidden matrix H.
- Stage 2 streams an 8-vector v and outputs y = H·v as eight 32-bit results with a done pulse.
- Sits between the operand-feed logic and the result sink in the accelerator datapath.

Parameters:
- N, 8, lanes/rows and number of hidden columns (fixed design point 8).
- DW, 8, input element width (unsigned).
- HW, 20, hidden accumulator/storage width.
- OW, 32, output element width.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-high (name kept per codebase; 1 = reset).
- valid_i  in  1  end-of-stream marker; qualified by en_i.
- en_i  in  1  beat enable; a beat occurs on each clock with en_i=1.
- din1_i  in  64  stage-1 matrix column; row r = din1_i[8r+7:8r].
- din2_i  in  8  stage-1 weight element for the current beat.
- din3_i  in  8  stage-2 vector element for the current beat.
- done_o  out  1  one-cycle pulse: matmul_o updated.
- matmul_o  out  256  result; y[r] = matmul_o[32r+31:32r].

Behaviour:
- Reset (async, level): phase=STAGE1, column index c=0, beat index k=0, all accumulators/H cleared. done_o=0, matmul_o=0.
- All state updates on rising clk_i. Cycles with en_i=0 change nothing, and valid_i is ignored.
- STAGE1 beat:
  - acc1[r] += din1_i[r]*din2_i for r=0..7 (16-bit product, HW-bit accumulator, modulo 2^HW).
  - If valid_i=1 on the same beat: H[r][c] <= acc1[r] + current product; acc1 <= 0; c <= c+1.
  - When the commit is for c=7: phase <= STAGE2 and c <= 0.
  - Beats per column are arbitrary, including 1. A beat with din=0 adds nothing but still commits if valid_i=1.
  - din3_i is ignored in STAGE1.
- STAGE2 beat:
  - acc2[r] += H[r][k]*din3_i (unsigned, OW-bit, modulo 2^32); k <= (k+1) mod 8.
  - If valid_i=1 on the same beat: matmul_o[r] <= acc2[r] + current product; done_o=1 in the next cycle only.
  - After that commit: acc2 <= 0, k <= 0, H cleared, phase <= STAGE1.
  - din1_i and din2_i are ignored in STAGE2.
- Latency: matmul_o and done_o are valid one clock after the stage-2 beat carrying valid_i.
- matmul_o holds its value until the next stage-2 commit or reset.
- done_o is 0 at all other times.
- More than 8 stage-2 beats before valid_i: k wraps and H columns are re-used (accumulates again).
- Reset mid-operation discards all partial sums and H, and returns to STAGE1, c=0.
- Implementation is single-cycle MAC per beat; no backpressure or ready output.

Test Plan:
- All-ones: 8 columns × 4 beats with din1 bytes=1, din2=1, valid_i on beat 4 (H all 4). Then 8 stage-2 beats din3=1 with valid_i on beat 8 → done_o pulses once, every y[r]=32.
- Column select, first column's beats with rows r0..r7 and weights:
  - beat 1: rows 1,3,2,1,1,1,2,1; din2=1.
  - beat 2: rows 1,3,1,2,2,1,3,2; din2=1.
  - beat 3: rows 1,2,1,1,3,1,2,3; din2=2.
  - beat 4: rows 2,1,1,2,1,2,1,1; din2=1.
  - Remaining 7 columns arbitrary. Stage 2 with din3 = 1,0,0,0,0,0,0,0 → y = 6,11,6,7,10,6,10,10.
- Stall and zero-beat commit:
  - Insert en_i=0 cycles with valid_i=1 and random data mid-stream → results identical to the all-ones case.
  - Committing column 7 on a separate en_i=1, din=0 beat → identical results.
- Overflow: all inputs 0xFF, 4 beats per column, H = 4·65025 = 260100. Stage 2 with din3=0xFF ×8 → y[r] = 260100·255·8 mod 2^32 = 530604000.
- Reset mid-stage-2 (after 3 beats), then rerun the all-ones case → y[r]=32, no spurious done_o.
- Back-to-back: two full all-ones runs, the second using din3=2 → two done_o pulses, second y[r]=64.
